mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: MEM_WORDS, default 18, number of 32-bit words in the attached data memory; word index >= MEM_WORDS is out of range.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  asynchronous active-high reset.
REQ-005 Port: req  input  1  CPU access request, sampled only in IDLE.
REQ-006 Port: we  input  1  1 = store, 0 = load.
REQ-007 Port: size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 Port: sext  input  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-009 Port: addr  input  32  byte address.
REQ-010 Port: wdata  input  32  store data, right-justified.
REQ-011 Port: rdata  output  32  load result, valid while ready=1.
REQ-012 Port: ready  output  1  one-cycle completion pulse.
REQ-013 Port: err  output  1  error flag, valid while ready=1.
REQ-014 Port: busy  output  1  high in every state except IDLE.
REQ-015 Port: mem_we  output  1  memory write enable; memory writes on the rising clk edge.
REQ-016 Port: mem_a  output  32  word-aligned memory byte address.
REQ-017 Port: mem_wd  output  32  memory write data.
REQ-018 Port: mem_rd  input  32  memory read data, combinational from mem_a.

Function
REQ-019 The FSM SHALL use the states IDLE, ACC, WR and RESP.
REQ-020 At the acceptance edge (IDLE, req=1), the block SHALL latch addr, we, size, sext and wdata, and SHALL ignore req in every other state.
REQ-021 An access SHALL be an error on any of these conditions: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=0; addr[31:2] >= MEM_WORDS.
REQ-022 On an error, the FSM SHALL go IDLE->RESP with err=1 and rdata=0, and SHALL never assert mem_we; ready SHALL be high in the 1st cycle after acceptance.
REQ-023 A load or word store SHALL follow IDLE->ACC->RESP->IDLE, with ready high in the 2nd cycle after acceptance.
REQ-024 A byte or halfword store SHALL follow IDLE->ACC->WR->RESP->IDLE, with ready high in the 3rd cycle after acceptance.
REQ-025 In ACC and WR, mem_a SHALL be {latched addr[31:2],2'b00}.
REQ-026 In ACC for a word store, mem_we SHALL be 1 and mem_wd SHALL be wdata; for all other accesses in ACC, mem_we SHALL be 0.
REQ-027 In ACC for a sub-word store, the block SHALL latch mem_rd; in WR, mem_we SHALL be 1 and mem_wd SHALL be the latched word with the addressed lane replaced.
REQ-028 Lanes SHALL be little-endian: byte k occupies bits [8k+7:8k] with k=addr[1:0]; the halfword occupies bits [16h+15:16h] with h=addr[1].
REQ-029 On a load, the addressed lane of mem_rd SHALL be captured at the ACC->RESP edge and extended to 32 bits per sext; a word load SHALL ignore sext.
REQ-030 mem_we SHALL be decoded from the state register only, so it is never high in IDLE or RESP.
REQ-031 ready and err SHALL be high only in RESP; a request presented in the RESP cycle SHALL be ignored and is accepted only in the following IDLE cycle.
REQ-032 Back-to-back accesses SHALL be separated by at least one IDLE cycle.

Reset
REQ-033 Reset SHALL asynchronously force the FSM to IDLE and set rdata, ready, err, busy, mem_we, mem_a and mem_wd to 0.
REQ-034 Reset asserted during ACC or WR SHALL drop mem_we immediately, SHALL complete no write, and SHALL discard the pending access without a ready pulse.

Verification
REQ-035 With word 3 = 0x8899AABB, a byte load at addr 0x0D with sext=1 SHALL return rdata 0xFFFFFFAA, and with sext=0 SHALL return 0x000000AA; both SHALL have ready in the 2nd cycle and err=0.
REQ-036 With word 3 = 0x8899AABB, a halfword store at addr 0x0E with wdata 0x00001234 SHALL leave word 3 = 0x1234AABB; mem_we SHALL be high only in the WR cycle, and ready SHALL be high in the 3rd cycle.
REQ-037 A word store at addr 0x10 with wdata 0xDEADBEEF, followed by a word load at addr 0x10, SHALL return 0xDEADBEEF.
REQ-038 A word load at addr 0x06, a halfword load at addr 0x01, size=11, and a load at addr 0x48 SHALL each give err=1 and rdata=0 with ready in the 1st cycle, and mem_we SHALL stay 0.
REQ-039 A byte store at addr 0x0C with reset asserted during WR SHALL leave word 3 unchanged, give no ready pulse, and return all outputs to 0.
REQ-040 A req held high continuously SHALL be accepted once per completed access, and busy SHALL be high from the cycle after acceptance through RESP.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Serialises one CPU load/store at a time onto a simple word-wide data
//   memory. Sub-word stores are done as read-modify-write (ACC reads, WR
//   writes the merged word). Misaligned, reserved-size or out-of-range
//   accesses never touch the memory and complete one cycle after acceptance
//   with err=1.
//
// Ports
//   clk, reset      : clock, asynchronous active-high reset
//   req             : access request, sampled only in IDLE
//   we, size, sext  : store/load, 00 byte / 01 half / 10 word, load sign-extend
//   addr, wdata     : byte address, right-justified store data
//   rdata, ready, err : load result, one-cycle completion pulse, error flag
//   busy            : high in every state except IDLE
//   mem_we, mem_a, mem_wd, mem_rd : data memory port (mem_rd combinational)
module mem_access_unit #(
   parameter int MEM_WORDS = 18
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic        busy,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   typedef enum logic [1:0] {IDLE, ACC, WR, RESP} state_t;

   localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

   state_t      state_reg, state_next;
   logic [31:0] addr_reg, wdata_reg, word_reg, rdata_reg;
   logic [1:0]  size_reg;
   logic        we_reg, sext_reg, err_reg;

   logic        req_err;
   logic        word_store;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_val;
   logic [31:0] merged;
   logic [3:0]  lane_hit;

   // Error classification uses the live request inputs so the decision is
   // ready at the acceptance edge and the FSM can skip straight to RESP.
   always_comb begin
      req_err = 1'b0;
      case (size)
         2'b11:   req_err = 1'b1;
         2'b01:   req_err = addr[0];
         2'b10:   req_err = |addr[1:0];
         default: req_err = 1'b0;
      endcase
      if ({2'b00, addr[31:2]} >= MEM_WORDS_W)
         req_err = 1'b1;
   end

   assign word_store = we_reg && (size_reg == 2'b10);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (req) state_next = req_err ? RESP : ACC;
         ACC:  state_next = (we_reg && !word_store) ? WR : RESP;
         WR:   state_next = RESP;
         RESP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Load lane extraction from the live memory word.
   always_comb begin
      case (addr_reg[1:0])
         2'd0:    ld_byte = mem_rd[7:0];
         2'd1:    ld_byte = mem_rd[15:8];
         2'd2:    ld_byte = mem_rd[23:16];
         default: ld_byte = mem_rd[31:24];
      endcase
      ld_half = addr_reg[1] ? mem_rd[31:16] : mem_rd[15:0];
      case (size_reg)
         2'b00:   ld_val = sext_reg ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
         2'b01:   ld_val = sext_reg ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
         default: ld_val = mem_rd;
      endcase
   end

   // Sub-word store merge: replace only the addressed byte lanes of the word
   // captured in ACC. A byte store always sources wdata[7:0]; a halfword
   // store sources the matching byte of wdata[15:0].
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_hit[gi] = (size_reg == 2'b00) ? (addr_reg[1:0] == 2'(gi))
                                                   : (addr_reg[1] == 1'(gi / 2));
         assign merged[8*gi +: 8] = !lane_hit[gi]       ? word_reg[8*gi +: 8] :
                                    (size_reg == 2'b00) ? wdata_reg[7:0] :
                                                          wdata_reg[8*(gi % 2) +: 8];
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         wdata_reg <= '0;
         word_reg  <= '0;
         rdata_reg <= '0;
         size_reg  <= '0;
         we_reg    <= 1'b0;
         sext_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && req) begin
            addr_reg  <= addr;
            wdata_reg <= wdata;
            size_reg  <= size;
            we_reg    <= we;
            sext_reg  <= sext;
            err_reg   <= req_err;
            rdata_reg <= '0;
         end
         if (state_reg == ACC) begin
            word_reg <= mem_rd;
            if (!we_reg)
               rdata_reg <= ld_val;
         end
      end
   end

   // All memory-side outputs are decoded from registered state, so an
   // asynchronous reset removes a pending write immediately.
   assign busy   = (state_reg != IDLE);
   assign ready  = (state_reg == RESP);
   assign err    = (state_reg == RESP) && err_reg;
   assign rdata  = rdata_reg;
   assign mem_we = ((state_reg == ACC) && word_store) || (state_reg == WR);
   assign mem_a  = ((state_reg == ACC) || (state_reg == WR)) ? {addr_reg[31:2], 2'b00} : 32'h0;
   assign mem_wd = ((state_reg == ACC) && word_store) ? wdata_reg :
                   (state_reg == WR)                  ? merged    : 32'h0;

endmodule
